scan_sequencer: RTL and testbench

- Upstream driver for the 3-to-8 enabled decoder: generates the 3-bit select `sel` and enable `ena` that feed the decoder's `a` and `ena` inputs.
- Steps through the channels enabled in an 8-bit mask, in ascending order with circular wrap.
- Holds each channel for a programmable number of cycles.
- Runs either one pass or continuously; supports start and stop control.

---
 rtl/scan_sequencer.sv | 137 +++++++++++++
 tb/tb_scan_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving a 3-to-8 decoder's select/enable.
// Define SCAN_GAP_EN to insert one ena=0 GAP cycle between consecutive channels.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic [2:0]         sel,
  output logic               ena,
  output logic               busy,
  output logic               wrap,
  output logic               done,
  output logic [1:0]         dbg_state
);

`ifdef SCAN_GAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_GAP = 2'd2} state_t;
  logic [2:0] nxt_q;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

  state_t             state_q;
  logic [2:0]         sel_q;
  logic               ena_q, busy_q, wrap_q, done_q, cont_q;
  logic [DWELL_W-1:0] cnt_q;

  logic               low_any, up_any;
  logic [2:0]         low_idx, up_idx;
  logic [DWELL_W-1:0] dwell_ld;

  // Lowest enabled channel overall, and lowest enabled channel strictly above sel.
  always_comb begin
    low_any = |mask;
    low_idx = 3'd0;
    up_any  = 1'b0;
    up_idx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) low_idx = 3'(i);
      if (mask[i] && (i > int'(sel_q))) begin
        up_any = 1'b1;
        up_idx = 3'(i);
      end
    end
  end

  assign dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SCAN_GAP_EN
      nxt_q   <= 3'd0;
`endif
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !stop && low_any) begin
            state_q <= S_RUN;
            sel_q   <= low_idx;
            ena_q   <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= dwell_ld;
            cont_q  <= cont;
          end
        end
        S_RUN: begin
          if (stop || (cnt_q == '0 && !low_any)) begin
            state_q <= S_IDLE;
            sel_q   <= 3'd0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else if (!up_any && !cont_q) begin
            state_q <= S_IDLE;
            sel_q   <= 3'd0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
`ifdef SCAN_GAP_EN
            // Break-before-make: drop ena with the old sel, wrap pulses here.
            state_q <= S_GAP;
            ena_q   <= 1'b0;
            nxt_q   <= up_any ? up_idx : low_idx;
            wrap_q  <= !up_any;
`else
            sel_q  <= up_any ? up_idx : low_idx;
            cnt_q  <= dwell_ld;
            wrap_q <= !up_any;
`endif
          end
        end
`ifdef SCAN_GAP_EN
        S_GAP: begin
          if (stop) begin
            state_q <= S_IDLE;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= S_RUN;
            sel_q   <= nxt_q;
            ena_q   <= 1'b1;
            cnt_q   <= dwell_ld;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign ena       = ena_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; gapless sequences by default, GAP sequence when SCAN_GAP_EN is defined.
module tb_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, stop, cont;
  logic [7:0] dwell, mask;
  logic [2:0] sel;
  logic       ena, busy, wrap, done;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .dwell(dwell), .mask(mask), .sel(sel), .ena(ena), .busy(busy),
    .wrap(wrap), .done(done), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: total=%0d", total);
    $fatal(1, "timeout");
  end

  // driver tasks: outputs are checked and inputs changed 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"}, 8'(sel), 8'd0);
    chk({tag, "_ena"}, 8'(ena), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_wrap"}, 8'(wrap), 8'd0);
    chk({tag, "_done"}, 8'(done), 8'd0);
  endtask

  task automatic start_scan(input logic [7:0] m, input logic [7:0] d, input logic c);
    mask = m; dwell = d; cont = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_scan();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; cont = 1'b0; dwell = 8'd1; mask = 8'hFF;
    tick();
    chk_idle("reset");
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    chk_idle("post_reset");

    // start with empty mask is refused
    start_scan(8'h00, 8'd1, 1'b1);
    chk_idle("mask0_start");
    tick();
    chk_idle("mask0_hold");

`ifndef SCAN_GAP_EN
    // single pass over all channels, dwell 1
    start_scan(8'hFF, 8'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("pass_sel", 8'(sel), 8'(i));
      chk("pass_ena", 8'(ena), 8'd1);
      chk("pass_done", 8'(done), 8'd0);
      tick();
    end
    chk("pass_done_pulse", 8'(done), 8'd1);
    chk("pass_done_wrap", 8'(wrap), 8'd0);
    chk("pass_end_busy", 8'(busy), 8'd0);
    chk("pass_end_ena", 8'(ena), 8'd0);
    tick();
    chk("pass_done_clear", 8'(done), 8'd0);
    start_scan(8'hFF, 8'd1, 1'b0);
    chk("restart_busy", 8'(busy), 8'd1);
    chk("restart_sel", 8'(sel), 8'd0);
    stop_scan();
    chk_idle("restart_stop");

    // continuous, mask 1010_0100, dwell 3
    foreach (exp_q[i]) exp_q.delete();
    exp_q = '{8'd2, 8'd2, 8'd2, 8'd5, 8'd5, 8'd5, 8'd7, 8'd7, 8'd7, 8'd2};
    start_scan(8'hA4, 8'd3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("cont_sel", 8'(sel), exp_q.pop_front());
      chk("cont_ena", 8'(ena), 8'd1);
      chk("cont_wrap", 8'(wrap), (i == 9) ? 8'd1 : 8'd0);
      if (i < 9) tick();
    end
    tick();
    chk("cont_wrap_clear", 8'(wrap), 8'd0);
    stop_scan();
    chk_idle("cont_stop");

    // dwell 0 on a single channel
    start_scan(8'h01, 8'd0, 1'b1);
    chk("single_first_wrap", 8'(wrap), 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_sel", 8'(sel), 8'd0);
      chk("single_ena", 8'(ena), 8'd1);
      chk("single_wrap", 8'(wrap), 8'd1);
    end
    stop_scan();
    chk_idle("single_stop");

    // stop on 2nd cycle of channel 5, start asserted alongside is ignored
    start_scan(8'h24, 8'd4, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("stop_pre_sel", 8'(sel), 8'd5);
    chk("stop_pre_busy", 8'(busy), 8'd1);
    stop = 1'b1; start = 1'b1;
    tick();
    chk_idle("stop_at_ch5");
    tick();
    chk_idle("stop_with_start");
    stop = 1'b0; start = 1'b0;

    // mask cleared mid-scan: idle at the advance, no done
    start_scan(8'h24, 8'd3, 1'b0);
    mask = 8'h00;
    tick();
    tick();
    chk("mask_clr_busy", 8'(busy), 8'd1);
    chk("mask_clr_sel", 8'(sel), 8'd2);
    tick();
    chk_idle("mask_clr_adv");
`else
    // GAP: mask 03, dwell 2, continuous
    begin
      logic [7:0] e_ena[7];
      logic [7:0] e_sel[7];
      logic [7:0] e_wrp[7];
      e_ena = '{8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1};
      e_sel = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0};
      e_wrp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
      start_scan(8'h03, 8'd2, 1'b1);
      for (int i = 0; i < 7; i++) begin
        chk("gap_ena", 8'(ena), e_ena[i]);
        chk("gap_sel", 8'(sel), e_sel[i]);
        chk("gap_wrap", 8'(wrap), e_wrp[i]);
        chk("gap_busy", 8'(busy), 8'd1);
        if (i < 6) tick();
      end
      tick();
      stop_scan();
      chk_idle("gap_stop");
    end
`endif

    // reset mid-scan
    start_scan(8'h81, 8'd5, 1'b1);
    chk("rst_mid_busy", 8'(busy), 8'd1);
    rst = 1'b1; start = 1'b1;
    tick();
    chk_idle("rst_mid");
    rst = 1'b0; start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
